// File: rtl/ps2_mouse_pkg.sv
// Shared types and helpers for the PS/2 mouse tracker.
package ps2_mouse_pkg;

    localparam int POS_W = 12;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;
    typedef enum logic [1:0] {BYTE0, BYTE1, BYTE2} pkt_state_t;

    typedef struct packed {
        logic       y_ovf;
        logic       x_ovf;
        logic       y_sign;
        logic       x_sign;
        logic       sync;
        logic [2:0] buttons;
    } ps2_status_t;

    function automatic logic [POS_W-1:0] clamp_pos(
        input logic signed [13:0] cand,
        input logic [POS_W-1:0]   max
    );
        logic signed [13:0] lim;
        lim = $signed({2'b00, max});
        if (cand < 0) begin
            return '0;
        end else if (cand > lim) begin
            return max;
        end else begin
            return cand[POS_W-1:0];
        end
    endfunction

endpackage

// File: rtl/ps2_mouse_tracker_rx.sv
// PS/2 byte receiver: line sync, clock glitch filter, frame FSM, timeout.
module ps2_rx_byte
    import ps2_mouse_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       pkt_busy,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       err_parity,
    output logic       err_frame,
    output logic       timeout
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0] clk_sync_q, clk_sync_d;
    logic [1:0] data_sync_q, data_sync_d;
    logic       filt_q, filt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic       strobe_q, strobe_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    rx_state_t  state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bcnt_q, bcnt_d;
    logic       par_ok_q, par_ok_d;
    logic       rx_valid_q, rx_valid_d;
    logic       err_parity_q, err_parity_d;
    logic       err_frame_q, err_frame_d;
    logic       data_bit;

    assign data_bit = data_sync_q[1];
    assign timeout  = (tcnt_q == TW'(TIMEOUT_CYCLES))
                    && ((state_q != IDLE) || pkt_busy);

    always_comb begin
        clk_sync_d   = {clk_sync_q[0], ps2_clk};
        data_sync_d  = {data_sync_q[0], ps2_data};
        filt_d       = filt_q;
        fcnt_d       = fcnt_q;
        strobe_d     = 1'b0;
        tcnt_d       = tcnt_q;
        state_d      = state_q;
        shift_d      = shift_q;
        bcnt_d       = bcnt_q;
        par_ok_d     = par_ok_q;
        rx_valid_d   = 1'b0;
        err_parity_d = 1'b0;
        err_frame_d  = 1'b0;

        if (clk_sync_q[1] == filt_q) begin
            fcnt_d = '0;
        end else if (fcnt_q == FW'(FILTER_LEN - 1)) begin
            fcnt_d   = '0;
            filt_d   = clk_sync_q[1];
            strobe_d = filt_q;
        end else begin
            fcnt_d = fcnt_q + 1'b1;
        end

        if (strobe_q) begin
            tcnt_d = '0;
        end else if (tcnt_q != TW'(TIMEOUT_CYCLES)) begin
            tcnt_d = tcnt_q + 1'b1;
        end

        if (timeout) begin
            state_d = IDLE;
        end else if (strobe_q) begin
            unique case (state_q)
                IDLE: begin
                    if (!data_bit) begin
                        state_d = DATA;
                        bcnt_d  = '0;
                    end else begin
                        err_frame_d = 1'b1;
                    end
                end
                DATA: begin
                    shift_d = {data_bit, shift_q[7:1]};
                    bcnt_d  = bcnt_q + 1'b1;
                    if (bcnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    par_ok_d = ^{shift_q, data_bit};
                    state_d  = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (!data_bit) begin
                        err_frame_d = 1'b1;
                    end else if (!par_ok_q) begin
                        err_parity_d = 1'b1;
                    end else begin
                        rx_valid_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync_q   <= 2'b11;
            data_sync_q  <= 2'b11;
            filt_q       <= 1'b1;
            fcnt_q       <= '0;
            strobe_q     <= 1'b0;
            tcnt_q       <= '0;
            state_q      <= IDLE;
            shift_q      <= '0;
            bcnt_q       <= '0;
            par_ok_q     <= 1'b0;
            rx_valid_q   <= 1'b0;
            err_parity_q <= 1'b0;
            err_frame_q  <= 1'b0;
        end else begin
            clk_sync_q   <= clk_sync_d;
            data_sync_q  <= data_sync_d;
            filt_q       <= filt_d;
            fcnt_q       <= fcnt_d;
            strobe_q     <= strobe_d;
            tcnt_q       <= tcnt_d;
            state_q      <= state_d;
            shift_q      <= shift_d;
            bcnt_q       <= bcnt_d;
            par_ok_q     <= par_ok_d;
            rx_valid_q   <= rx_valid_d;
            err_parity_q <= err_parity_d;
            err_frame_q  <= err_frame_d;
        end
    end

    assign rx_data    = shift_q;
    assign rx_valid   = rx_valid_q;
    assign err_parity = err_parity_q;
    assign err_frame  = err_frame_q;

endmodule

// File: rtl/ps2_mouse_tracker.sv
// PS/2 mouse tracker: packet assembly and clamped absolute cursor position.
module ps2_mouse_tracker
    import ps2_mouse_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int X_MAX          = 1279,
    parameter int Y_MAX          = 1023,
    parameter int X_INIT         = 640,
    parameter int Y_INIT         = 512
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ps2_clk,
    input  logic             ps2_data,
    output logic [POS_W-1:0] mouse_x_pos,
    output logic [POS_W-1:0] mouse_y_pos,
    output logic [2:0]       mouse_buttons,
    output logic             new_event,
    output logic             err_parity,
    output logic             err_frame
);

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_err_parity;
    logic       rx_err_frame;
    logic       timeout;

    pkt_state_t  pkt_q, pkt_d;
    ps2_status_t status_q, status_d;
    logic [7:0]  dx_q, dx_d;
    logic [POS_W-1:0] x_q, x_d, y_q, y_d;
    logic [2:0]  btn_q, btn_d;
    logic        new_event_q, new_event_d;
    logic        err_parity_q, err_parity_d;
    logic        err_frame_q, err_frame_d;

    logic signed [13:0] dx_ext, dy_ext, x_cand, y_cand;

    ps2_rx_byte #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .pkt_busy   (pkt_q != BYTE0),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .err_parity (rx_err_parity),
        .err_frame  (rx_err_frame),
        .timeout    (timeout)
    );

    // An overflowed axis contributes no movement.
    assign dx_ext = status_q.x_ovf ? '0 : {{6{status_q.x_sign}}, dx_q};
    assign dy_ext = status_q.y_ovf ? '0 : {{6{status_q.y_sign}}, rx_data};
    assign x_cand = $signed({2'b00, x_q}) + dx_ext;
    assign y_cand = $signed({2'b00, y_q}) - dy_ext;

    always_comb begin
        pkt_d        = pkt_q;
        status_d     = status_q;
        dx_d         = dx_q;
        x_d          = x_q;
        y_d          = y_q;
        btn_d        = btn_q;
        new_event_d  = 1'b0;
        err_parity_d = rx_err_parity;
        err_frame_d  = rx_err_frame | timeout;

        if (rx_err_parity || rx_err_frame || timeout) begin
            pkt_d = BYTE0;
        end else if (rx_valid) begin
            unique case (pkt_q)
                BYTE0: begin
                    if (rx_data[3]) begin
                        status_d = ps2_status_t'(rx_data);
                        pkt_d    = BYTE1;
                    end else begin
                        err_frame_d = 1'b1;
                    end
                end
                BYTE1: begin
                    dx_d  = rx_data;
                    pkt_d = BYTE2;
                end
                BYTE2: begin
                    pkt_d       = BYTE0;
                    new_event_d = status_q.sync;
                    btn_d       = status_q.buttons;
                    x_d         = clamp_pos(x_cand, POS_W'(X_MAX));
                    y_d         = clamp_pos(y_cand, POS_W'(Y_MAX));
                end
                default: pkt_d = BYTE0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_q        <= BYTE0;
            status_q     <= '0;
            dx_q         <= '0;
            x_q          <= POS_W'(X_INIT);
            y_q          <= POS_W'(Y_INIT);
            btn_q        <= '0;
            new_event_q  <= 1'b0;
            err_parity_q <= 1'b0;
            err_frame_q  <= 1'b0;
        end else begin
            pkt_q        <= pkt_d;
            status_q     <= status_d;
            dx_q         <= dx_d;
            x_q          <= x_d;
            y_q          <= y_d;
            btn_q        <= btn_d;
            new_event_q  <= new_event_d;
            err_parity_q <= err_parity_d;
            err_frame_q  <= err_frame_d;
        end
    end

    assign mouse_x_pos   = x_q;
    assign mouse_y_pos   = y_q;
    assign mouse_buttons = btn_q;
    assign new_event     = new_event_q;
    assign err_parity    = err_parity_q;
    assign err_frame     = err_frame_q;

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Bench for ps2_mouse_tracker: bit-banged PS/2 frames, scoreboard of positions.
module tb_ps2_mouse_tracker;

    localparam int HALF = 20;
    localparam int GAP  = 30;
    localparam int TMO  = 3000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [11:0] mouse_x_pos, mouse_y_pos;
    logic [2:0]  mouse_buttons;
    logic        new_event, err_parity, err_frame;

    int errors = 0;
    int checks = 0;
    int n_ev = 0, n_par = 0, n_frm = 0;
    int mx = 640, my = 512, mb = 0;
    logic [26:0] sb[$];

    ps2_mouse_tracker #(
        .FILTER_LEN     (8),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ps2_clk       (ps2_clk),
        .ps2_data      (ps2_data),
        .mouse_x_pos   (mouse_x_pos),
        .mouse_y_pos   (mouse_y_pos),
        .mouse_buttons (mouse_buttons),
        .new_event     (new_event),
        .err_parity    (err_parity),
        .err_frame     (err_frame)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int clampi(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (err_parity) n_par++;
            if (err_frame) n_frm++;
            if (new_event) begin
                n_ev++;
                if (sb.size() == 0) begin
                    chk("unexpected_event", 1, 0);
                end else begin
                    logic [26:0] e;
                    e = sb.pop_front();
                    chk("ev_x", int'(mouse_x_pos), int'(e[26:15]));
                    chk("ev_y", int'(mouse_y_pos), int'(e[14:3]));
                    chk("ev_btn", int'(mouse_buttons), int'(e[2:0]));
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par,
                              input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            cycles(HALF);
            ps2_clk = 1'b0;
            cycles(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        cycles(GAP);
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2);
        int dx, dy;
        if (b0[3]) begin
            dx = b0[6] ? 0 : (b0[4] ? int'(b1) - 256 : int'(b1));
            dy = b0[7] ? 0 : (b0[5] ? int'(b2) - 256 : int'(b2));
            mx = clampi(mx + dx, 1279);
            my = clampi(my - dy, 1023);
            mb = int'(b0[2:0]);
            sb.push_back({mx[11:0], my[11:0], mb[2:0]});
        end
        send_frame(b0, 1'b0, 11);
        send_frame(b1, 1'b0, 11);
        send_frame(b2, 1'b0, 11);
        cycles(20);
    endtask

    task automatic goto_xy(input int tx, input int ty);
        int dx, dy;
        logic [7:0] b0;
        while (mx != tx || my != ty) begin
            dx = tx - mx;
            dy = my - ty;
            if (dx > 255) dx = 255;
            if (dx < -256) dx = -256;
            if (dy > 255) dy = 255;
            if (dy < -256) dy = -256;
            b0 = 8'h08;
            b0[4] = (dx < 0);
            b0[5] = (dy < 0);
            send_pkt(b0, dx[7:0], dy[7:0]);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ev0, par0, frm0;
        cycles(5);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_x", int'(mouse_x_pos), 640);
        chk("rst_y", int'(mouse_y_pos), 512);
        chk("rst_btn", int'(mouse_buttons), 0);
        chk("rst_pulses", int'({new_event, err_parity, err_frame}), 0);

        send_pkt(8'h08, 8'h05, 8'h03);
        @(negedge clk);
        chk("tp1_x", int'(mouse_x_pos), 645);
        chk("tp1_y", int'(mouse_y_pos), 509);
        chk("tp1_ev", n_ev, 1);

        send_pkt(8'h19, 8'hFB, 8'h00);
        @(negedge clk);
        chk("tp2_x", int'(mouse_x_pos), 640);
        chk("tp2_btn", int'(mouse_buttons), 1);

        goto_xy(2, my);
        send_pkt(8'h18, 8'hF6, 8'h00);
        @(negedge clk);
        chk("clamp_x0", int'(mouse_x_pos), 0);

        goto_xy(mx, 1020);
        send_pkt(8'h28, 8'h00, 8'hF0);
        @(negedge clk);
        chk("clamp_ymax", int'(mouse_y_pos), 1023);

        send_pkt(8'h48, 8'h7F, 8'h02);
        @(negedge clk);
        chk("ovf_x", int'(mouse_x_pos), 0);
        chk("ovf_y", int'(mouse_y_pos), 1021);

        ev0 = n_ev; par0 = n_par;
        send_frame(8'h08, 1'b0, 11);
        send_frame(8'h01, 1'b0, 11);
        send_frame(8'h01, 1'b1, 11);
        cycles(20);
        chk("par_err", n_par - par0, 1);
        chk("par_noev", n_ev - ev0, 0);
        send_pkt(8'h08, 8'h01, 8'h01);
        @(negedge clk);
        chk("after_par_x", int'(mouse_x_pos), 1);
        chk("after_par_y", int'(mouse_y_pos), 1020);

        ev0 = n_ev; frm0 = n_frm;
        send_frame(8'h05, 1'b0, 11);
        cycles(20);
        chk("sync_rej", n_frm - frm0, 1);
        chk("sync_noev", n_ev - ev0, 0);

        frm0 = n_frm;
        send_frame(8'h08, 1'b0, 4);
        cycles(TMO / 2);
        chk("tmo_early", n_frm - frm0, 0);
        cycles(TMO / 2 + 200);
        chk("tmo_err", n_frm - frm0, 1);
        send_pkt(8'h0A, 8'h10, 8'h20);

        ev0 = n_ev; par0 = n_par; frm0 = n_frm;
        send_frame(8'h08, 1'b0, 11);
        send_frame(8'h33, 1'b0, 6);
        reset = 1'b1;
        cycles(3);
        reset = 1'b0;
        mx = 640; my = 512; mb = 0;
        @(negedge clk);
        chk("mid_rst_x", int'(mouse_x_pos), 640);
        chk("mid_rst_y", int'(mouse_y_pos), 512);
        chk("mid_rst_btn", int'(mouse_buttons), 0);
        cycles(300);
        chk("mid_rst_quiet", (n_ev - ev0) + (n_par - par0) + (n_frm - frm0), 0);
        send_pkt(8'h0C, 8'h03, 8'hFD);

        cycles(100);
        chk("sb_empty", sb.size(), 0);
        chk("par_total", n_par, 1);
        chk("frm_total", n_frm, 2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
